// File: rtl/sa_cdma_wt_wgs_pkg.sv
// rtl/sa_cdma_wt_wgs_pkg.sv - shared types and constants for the CDMA weight-group-status path.
package sa_cdma_wt_wgs_pkg;

  localparam int WGS_DW         = 32;
  localparam int WGS_FIFO_DEPTH = 32;

  typedef logic [WGS_DW-1:0] wgs_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sa_rr_pick.sv
// rtl/sa_rr_pick.sv - combinational round-robin picker: first request at or after ptr wins.
module sa_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  // Walk from the farthest candidate back to ptr so the nearest one overwrites.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sa_cdma_wt_wgs_arb.sv
// rtl/sa_cdma_wt_wgs_arb.sv - packet-locked round-robin arbiter in front of the WGS FIFO write port.
// Optional per-requester packet and stall counters under SA_CDMA_WT_WGS_ARB_STATS_EN.
module sa_cdma_wt_wgs_arb
  import sa_cdma_wt_wgs_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = WGS_DW,
  parameter int MAX_PKT = 16
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic [NUM_REQ-1:0]    req_vld,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic                  fifo_wr_req,
  output logic [DW-1:0]         fifo_wr_data,
  input  logic                  fifo_wr_ready,
  output logic                  arb_busy,
  output logic                  pkt_err
`ifdef SA_CDMA_WT_WGS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] pkt_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_PKT + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_req_q, wr_req_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          pkt_err_q, pkt_err_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic          out_free;
  logic          beat_vld;
  logic          beat_last;
  logic [DW-1:0] beat_data;
  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic          wd_hit;
  logic          pkt_end;

  sa_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req     (req_vld),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The output register can take a beat when empty or when it drains this cycle.
  assign out_free  = !wr_req_q || fifo_wr_ready;
  assign beat_vld  = req_vld[gnt_q];
  assign beat_last = req_last[gnt_q];
  assign beat_data = req_data[int'(gnt_q)*DW +: DW];
  assign accept    = (state_q == LOCK) && out_free && beat_vld;
  assign cnt_inc   = cnt_q + CW'(1);
  assign wd_hit    = (cnt_inc == CW'(MAX_PKT));
  assign pkt_end   = accept && (beat_last || wd_hit);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pkt_err_d = pkt_err_q;
    req_rdy   = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        req_rdy[gnt_q] = out_free;
        if (accept) begin
          cnt_d = cnt_inc;
          if (wd_hit && !beat_last) pkt_err_d = 1'b1;
          if (pkt_end) begin
            state_d = IDLE;
            cnt_d   = '0;
            ptr_d   = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + IW'(1);
          end
        end
      end
    endcase
  end

  // Load wins over drain, so a simultaneous load and drain keeps the request high.
  always_comb begin
    wr_req_d  = wr_req_q;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_req_d  = 1'b1;
      wr_data_d = beat_data;
    end else if (fifo_wr_ready) begin
      wr_req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_data_q <= '0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_req_q  <= wr_req_d;
      wr_data_q <= wr_data_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  assign fifo_wr_req  = wr_req_q;
  assign fifo_wr_data = wr_data_q;
  assign arb_busy     = (state_q == LOCK) || wr_req_q;
  assign pkt_err      = pkt_err_q;

`ifdef SA_CDMA_WT_WGS_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pkt_end && (pkt_cnt_q[int'(gnt_q)*16 +: 16] != 16'hFFFF))
      pkt_cnt_d[int'(gnt_q)*16 +: 16] = pkt_cnt_q[int'(gnt_q)*16 +: 16] + 16'd1;
    if (wr_req_q && !fifo_wr_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sa_cdma_wt_wgs_arb.sv
// tb/tb_sa_cdma_wt_wgs_arb.sv - directed bench with a packet-level arbitration model and write scoreboard.
module tb_sa_cdma_wt_wgs_arb;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXP = 16;

  logic            clk = 1'b0;
  logic            reset_;
  logic [N-1:0]    req_vld, req_last, req_rdy;
  logic [N*DW-1:0] req_data;
  logic            fifo_wr_req;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_ready;
  logic            arb_busy, pkt_err;
`ifdef SA_CDMA_WT_WGS_ARB_STATS_EN
  logic [N*16-1:0] pkt_cnt;
  logic [15:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  sa_cdma_wt_wgs_arb #(.NUM_REQ(N), .DW(DW), .MAX_PKT(MAXP)) dut (
    .clk           (clk),
    .reset_        (reset_),
    .req_vld       (req_vld),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_rdy       (req_rdy),
    .fifo_wr_req   (fifo_wr_req),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_ready (fifo_wr_ready),
    .arb_busy      (arb_busy),
    .pkt_err       (pkt_err)
`ifdef SA_CDMA_WT_WGS_ARB_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [32:0] src_q [N][$];
  logic [32:0] mq    [N][$];
  logic [31:0] exp_q [$];
  logic [31:0] wr_log [$];
  int          wr_times [$];
  int          m_ptr = 0;
  bit          m_err = 1'b0;
  int          m_pk [N];

  int          stall_left  = 0;
  int          stall_len   = 5;
  bit          stall_armed = 1'b0;
  logic [31:0] stall_word  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_beats(input int r, input logic [31:0] base, input int n, input bit with_last);
    for (int b = 0; b < n; b++) begin
      src_q[r].push_back({with_last && (b == n - 1), base + 32'(b)});
      mq[r].push_back({with_last && (b == n - 1), base + 32'(b)});
    end
  endtask

  // Packet-level model: round-robin over requesters holding packets, a packet
  // ends at last or after MAXP beats (watchdog), then the pointer moves past it.
  task automatic model_flush();
    bit pending;
    pending = 1'b1;
    while (pending) begin
      int  r;
      int  cnt;
      bit  done;
      logic [32:0] b;
      r = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (r < 0 && mq[j].size() > 0) r = j;
      end
      if (r < 0) begin
        pending = 1'b0;
      end else begin
        cnt  = 0;
        done = 1'b0;
        while (!done && mq[r].size() > 0) begin
          b = mq[r].pop_front();
          exp_q.push_back(b[31:0]);
          cnt++;
          if (b[32]) done = 1'b1;
          else if (cnt == MAXP) begin
            done  = 1'b1;
            m_err = 1'b1;
          end
        end
        m_pk[r]++;
        m_ptr = (r + 1) % N;
      end
    end
  endtask

  function automatic bit srcs_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_vld[i]            = 1'b1;
        req_last[i]           = src_q[i][0][32];
        req_data[i*DW +: DW]  = src_q[i][0][31:0];
      end else begin
        req_vld[i]            = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (srcs_empty() && exp_q.size() == 0 && !arb_busy) break;
    end
    check({name, "_drain"}, 32'(k < 500), 32'd1);
  endtask

  // Requester and FIFO-side driver: handshakes sampled mid-cycle, inputs updated just after the edge.
  initial begin
    logic [N-1:0] fire;
    req_vld       = '0;
    req_last      = '0;
    req_data      = '0;
    fifo_wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      fire = req_vld & req_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive_srcs();
      if (stall_armed && fifo_wr_req && fifo_wr_data == stall_word) begin
        stall_armed = 1'b0;
        stall_left  = stall_len;
      end
      if (stall_left > 0) begin
        fifo_wr_ready = 1'b0;
        stall_left--;
      end else begin
        fifo_wr_ready = 1'b1;
      end
    end
  end

  // Per-cycle compare against the scoreboard and the output-register rules.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_ !== 1'b1) begin
        prev_stall = 1'b0;
        continue;
      end
      check("req_rdy_onehot0", 32'($onehot0(req_rdy)), 32'd1);
      if (fifo_wr_req && !fifo_wr_ready) check("req_rdy_when_full", 32'(req_rdy), 32'd0);
      if (fifo_wr_req) check("busy_with_req", 32'(arb_busy), 32'd1);
      if (prev_stall) begin
        check("hold_req", 32'(fifo_wr_req), 32'd1);
        check("hold_data", fifo_wr_data, prev_data);
      end
      if (fifo_wr_req && fifo_wr_ready) begin
        if (exp_q.size() == 0) check("unexpected_write", fifo_wr_data, 32'hFFFF_FFFF);
        else                   check("wr_data", fifo_wr_data, exp_q.pop_front());
        wr_log.push_back(fifo_wr_data);
        wr_times.push_back(cyc);
      end
      prev_stall = fifo_wr_req && !fifo_wr_ready;
      prev_data  = fifo_wr_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int          k;
    int          base_i;
    int          t2_off [10]  = '{0, 1, 3, 4, 6, 7, 9, 10, 12, 13};
    logic [31:0] t2_data [10] = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h300,
                                  32'h301, 32'h400, 32'h401, 32'h110, 32'h111};
    bit          t1_req  [6]  = '{0, 0, 1, 1, 1, 0};
    bit          t1_busy [6]  = '{0, 1, 1, 1, 1, 0};
    logic [31:0] t1_data [6]  = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h0};

    for (int i = 0; i < N; i++) m_pk[i] = 0;
    reset_ = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_req", 32'(fifo_wr_req), 32'd0);
    check("rst_wr_data", fifo_wr_data, 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_busy", 32'(arb_busy), 32'd0);
    check("rst_pkt_err", 32'(pkt_err), 32'd0);
    #1 reset_ = 1'b1;

    // All four requesters with 2-beat packets, requester 0 holding a second one.
    @(posedge clk); #2;
    add_beats(0, 32'h100, 2, 1'b1);
    add_beats(0, 32'h110, 2, 1'b1);
    add_beats(1, 32'h200, 2, 1'b1);
    add_beats(2, 32'h300, 2, 1'b1);
    add_beats(3, 32'h400, 2, 1'b1);
    base_i = wr_log.size();
    model_flush();
    wait_drain("rr4");
    check("rr4_count", 32'(wr_log.size() - base_i), 32'd10);
    if (wr_log.size() - base_i == 10) begin
      for (int i = 0; i < 10; i++) begin
        check("rr4_order", wr_log[base_i + i], t2_data[i]);
        check("rr4_timing", 32'(wr_times[base_i + i] - wr_times[base_i]), 32'(t2_off[i]));
      end
    end

    // Single 3-beat packet: latency and busy profile.
    @(posedge clk); #2;
    add_beats(0, 32'h11, 1, 1'b0);
    add_beats(0, 32'h22, 1, 1'b0);
    add_beats(0, 32'h33, 1, 1'b1);
    model_flush();
    for (k = 0; k < 20 && !req_vld[0]; k++) @(negedge clk);
    check("lat_vld_seen", 32'(req_vld[0]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      check("lat_wr_req", 32'(fifo_wr_req), 32'(t1_req[c]));
      check("lat_busy", 32'(arb_busy), 32'(t1_busy[c]));
      if (t1_req[c]) check("lat_data", fifo_wr_data, t1_data[c]);
    end
    wait_drain("single");

    // Backpressure for 5 cycles with 0xAB in the output register.
    @(posedge clk); #2;
    stall_word  = 32'hAB;
    stall_len   = 5;
    stall_armed = 1'b1;
    add_beats(1, 32'hAA, 4, 1'b1);
    model_flush();
    for (k = 0; k < 50 && fifo_wr_ready; k++) @(negedge clk);
    check("bp_stall_seen", 32'(fifo_wr_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check("bp_hold_data", fifo_wr_data, 32'hAB);
      check("bp_rdy_zero", 32'(req_rdy), 32'd0);
    end
    @(negedge clk);
    check("bp_released", 32'(fifo_wr_ready), 32'd1);
    wait_drain("bp");

    // Watchdog: 16 beats without last from requester 2, then requester 3.
    @(posedge clk); #2;
    add_beats(2, 32'h500, 16, 1'b0);
    add_beats(3, 32'h600, 1, 1'b1);
    model_flush();
    for (k = 0; k < 100 && !(fifo_wr_req && fifo_wr_data == 32'h50E); k++) @(negedge clk);
    check("wd_beat15_err", 32'(pkt_err), 32'd0);
    @(negedge clk);
    check("wd_beat16_data", fifo_wr_data, 32'h50F);
    check("wd_beat16_err", 32'(pkt_err), 32'd1);
    wait_drain("wd");
    check("wd_next_grant", wr_log[wr_log.size() - 1], 32'h600);
    check("wd_model_err", 32'(pkt_err), 32'(m_err));

    // Reset in the middle of a packet, with the pointer advanced past requester 1.
    @(posedge clk); #2;
    add_beats(1, 32'h700, 1, 1'b1);
    add_beats(1, 32'h710, 4, 1'b1);
    model_flush();
    for (k = 0; k < 100 && !(fifo_wr_req && fifo_wr_data == 32'h711); k++) @(negedge clk);
    check("mr_in_lock", 32'(arb_busy), 32'd1);
    check("mr_err_sticky", 32'(pkt_err), 32'd1);
    #1 reset_ = 1'b0;
    #1;
    check("mr_wr_req", 32'(fifo_wr_req), 32'd0);
    check("mr_wr_data", fifo_wr_data, 32'd0);
    check("mr_req_rdy", 32'(req_rdy), 32'd0);
    check("mr_busy", 32'(arb_busy), 32'd0);
    check("mr_pkt_err", 32'(pkt_err), 32'd0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mq[i].delete();
      m_pk[i] = 0;
    end
    exp_q.delete();
    m_ptr = 0;
    m_err = 1'b0;
    drive_srcs();
    repeat (2) @(negedge clk);
    #1 reset_ = 1'b1;
    @(posedge clk); #2;
    add_beats(2, 32'h800, 1, 1'b1);
    add_beats(0, 32'h900, 1, 1'b1);
    model_flush();
    wait_drain("mr");
    check("mr_restart_first", wr_log[wr_log.size() - 2], 32'h900);
    check("mr_restart_second", wr_log[wr_log.size() - 1], 32'h800);

`ifdef SA_CDMA_WT_WGS_ARB_STATS_EN
    // Two more requester-2 packets with a 7-cycle stall.
    @(posedge clk); #2;
    stall_word  = 32'hA01;
    stall_len   = 7;
    stall_armed = 1'b1;
    add_beats(2, 32'hA00, 2, 1'b1);
    add_beats(2, 32'hA10, 2, 1'b1);
    model_flush();
    wait_drain("stats");
    check("stats_pkt2", 32'(pkt_cnt[2*16 +: 16]), 32'd3);
    check("stats_pkt2_model", 32'(pkt_cnt[2*16 +: 16]), 32'(m_pk[2]));
    check("stats_pkt0", 32'(pkt_cnt[0 +: 16]), 32'(m_pk[0]));
    check("stats_stall", 32'(stall_cnt), 32'd7);
`endif

    check("exp_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
